// File: rtl/mux2_sel_pkg.sv
// Shared constants for the MIPS datapath word selector: default data width
// and the select encodings.
package mux2_sel_pkg;

  localparam int DATA_W = 32;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux2_sel_pkg

// File: rtl/mux2_sel.sv
// Two-input word selector with a combinational output X and a registered,
// valid-qualified copy x_q for use as a pipeline stage.
module mux2_sel
  import mux2_sel_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] x_q,
  output logic             x_q_valid
);

  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] x_d;
  logic             x_q_valid_d;

  // One select expression feeds both X and the register; an unknown sel
  // merges A/B bitwise through the ?: operator.
  always_comb begin
    sel_word = (sel == SEL_B) ? B : A;
  end

  assign X = sel_word;

  always_comb begin
    x_d         = x_q;
    x_q_valid_d = 1'b0;
    if (in_valid) begin
      x_d         = sel_word;
      x_q_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= RESET_VAL;
      x_q_valid <= 1'b0;
    end else begin
      x_q       <= x_d;
      x_q_valid <= x_q_valid_d;
    end
  end

endmodule : mux2_sel

// File: tb/tb_mux2_sel.sv
// Directed bench for mux2_sel: checks the combinational select immediately
// and the registered copy through a queue of expected captures.
module tb_mux2_sel;

  localparam int          W      = 32;
  localparam logic [31:0] RST_V  = 32'h0000_0000;

  typedef struct packed {
    logic [W-1:0] data;
    logic         valid;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         sel;
  logic         in_valid;
  logic [W-1:0] x_out;
  logic [W-1:0] x_q;
  logic         x_q_valid;

  int compared;
  int mismatched;

  exp_t         sb_q[$];
  logic [W-1:0] model_xq;

  mux2_sel #(
    .WIDTH     (W),
    .RESET_VAL (RST_V)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a_in),
    .B         (b_in),
    .sel       (sel),
    .in_valid  (in_valid),
    .X         (x_out),
    .x_q       (x_q),
    .x_q_valid (x_q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one clocked step: inputs at the falling edge, X checked right away,
  // the expected register contents queued and then compared after the edge.
  task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic s,
                               input logic v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    a_in = a; b_in = b; sel = s; in_valid = v;
    #1;
    checkOutput({tag, "_X"}, x_out, s ? b : a);
    if (v) model_xq = s ? b : a;
    e.data  = model_xq;
    e.valid = v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_sb: observed empty queue expected entry", tag);
    end else begin
      got = sb_q.pop_front();
      checkOutput({tag, "_xq"}, x_q, got.data);
      checkOutput({tag, "_vld"}, {{(W-1){1'b0}}, x_q_valid},
                  {{(W-1){1'b0}}, got.valid});
    end
  endtask

  task automatic combStep(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] exp);
    a_in = a; b_in = b; sel = s;
    #1;
    checkOutput(tag, x_out, exp);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    model_xq   = RST_V;
    rst_n      = 1'b0;
    a_in       = '0;
    b_in       = '0;
    sel        = 1'b0;
    in_valid   = 1'b0;

    #2;
    checkOutput("reset_xq", x_q, RST_V);
    checkOutput("reset_vld", {31'b0, x_q_valid}, 32'h0);

    for (int i = 0; i < 4; i++)
      combStep("selA_hold", 32'h0000ffff, 32'h00000000, 1'b0, 32'h0000ffff);
    for (int i = 0; i < 4; i++)
      combStep("selB_hold", 32'h0000ffff, 32'h00000000, 1'b1, 32'h00000000);

    combStep("toggle0", 32'hdeadbeef, 32'h12345678, 1'b0, 32'hdeadbeef);
    combStep("toggle1", 32'hdeadbeef, 32'h12345678, 1'b1, 32'h12345678);
    combStep("toggle2", 32'hdeadbeef, 32'h12345678, 1'b0, 32'hdeadbeef);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("idle_after_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus("cap_A", 32'h11111111, 32'h22222222, 1'b0, 1'b1);

    // Asynchronous reset away from any clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_xq", x_q, RST_V);
    checkOutput("async_rst_vld", {31'b0, x_q_valid}, 32'h0);
    combStep("async_rst_X", 32'hdeadbeef, 32'h12345678, 1'b1, 32'h12345678);
    model_xq = RST_V;
    @(posedge clk);
    #1;
    checkOutput("rst_held_xq", x_q, RST_V);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("cap_cafe", 32'h0, 32'hcafef00d, 1'b1, 1'b1);
    applyStimulus("hold_cafe", 32'h55555555, 32'haaaaaaaa, 1'b0, 1'b0);
    applyStimulus("hold_cafe2", 32'h55555555, 32'haaaaaaaa, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++)
      applyStimulus("sweep", 32'hffffffff, 32'h00000000, i[0], 1'b1);
    applyStimulus("sweep_end", 32'h12345678, 32'h9abcdef0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule : tb_mux2_sel
